// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-4 nibble stream demultiplexer.
package stream_demux_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned DEF_DW    = 4;
  localparam int unsigned DEF_CNT_W = 8;

  typedef logic [SEL_W-1:0] lane_sel_t;

endpackage : stream_demux_pkg

// File: rtl/demux_lane_reg.sv
// One-entry lane holding register with an accepted-beat counter.
// A load in the same cycle as a drain replaces the held beat without a bubble.
module demux_lane_reg
  import stream_demux_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [DW-1:0]    load_data,
  output logic             valid,
  output logic [DW-1:0]    data,
  output logic [CNT_W-1:0] cnt
);

  logic             valid_q, valid_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: load wins, otherwise a drained beat empties the lane.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (valid_q && drain) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign cnt   = cnt_q;

endmodule : demux_lane_reg

// File: rtl/stream_demux4.sv
// Registered 1-to-4 stream demultiplexer with per-lane valid/ready.
// Optional build macro DEMUX_RR_EN: destination comes from an internal
// round-robin pointer that advances only on accepted beats; in_sel is ignored.
module stream_demux4
  import stream_demux_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [DW-1:0]    in_data,
  output logic [LANES-1:0] out_valid,
  input  logic [LANES-1:0] out_ready,
  output logic [DW-1:0]    out_data0,
  output logic [DW-1:0]    out_data1,
  output logic [DW-1:0]    out_data2,
  output logic [DW-1:0]    out_data3,
  output logic [CNT_W-1:0] lane_cnt0,
  output logic [CNT_W-1:0] lane_cnt1,
  output logic [CNT_W-1:0] lane_cnt2,
  output logic [CNT_W-1:0] lane_cnt3
);

  lane_sel_t        dst;
  logic             accept;
  logic [LANES-1:0] load;
  logic [DW-1:0]    lane_data [LANES];
  logic [CNT_W-1:0] lane_cnt  [LANES];

`ifdef DEMUX_RR_EN
  lane_sel_t ptr_q, ptr_d;
  logic      unused_sel;

  // Pointer moves on to the next lane only when a beat is taken.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ptr_q + lane_sel_t'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign dst        = ptr_q;
  assign unused_sel = ^in_sel;
`else
  assign dst = in_sel;
`endif

  // Destination lane can take a beat when empty or draining this cycle.
  assign in_ready = !out_valid[dst] || out_ready[dst];
  assign accept   = in_valid && in_ready;

  // One-hot load strobe towards the destination lane.
  always_comb begin
    load = '0;
    if (accept) begin
      load[dst] = 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane_reg #(
      .DW    (DW),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .drain     (out_ready[i]),
      .load_data (in_data),
      .valid     (out_valid[i]),
      .data      (lane_data[i]),
      .cnt       (lane_cnt[i])
    );
  end

  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];
  assign out_data3 = lane_data[3];
  assign lane_cnt0 = lane_cnt[0];
  assign lane_cnt1 = lane_cnt[1];
  assign lane_cnt2 = lane_cnt[2];
  assign lane_cnt3 = lane_cnt[3];

endmodule : stream_demux4

// File: tb/tb_stream_demux4.sv
// Bench for stream_demux4: directed scenarios plus random traffic against a
// lane-occupancy reference model. Honours DEMUX_RR_EN when defined.
module tb_stream_demux4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_sel = '0;
  logic [3:0] in_data = '0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [7:0] lane_cnt0, lane_cnt1, lane_cnt2, lane_cnt3;

  stream_demux4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .lane_cnt0 (lane_cnt0),
    .lane_cnt1 (lane_cnt1),
    .lane_cnt2 (lane_cnt2),
    .lane_cnt3 (lane_cnt3)
  );

  always #5 clk = ~clk;

  logic [3:0] od [4];
  logic [7:0] oc [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign oc[0] = lane_cnt0;
  assign oc[1] = lane_cnt1;
  assign oc[2] = lane_cnt2;
  assign oc[3] = lane_cnt3;

  int errors = 0;
  int checks = 0;

  // Reference model: each lane either holds a beat or is empty.
  bit         m_full [4];
  logic [3:0] m_last [4];
  int         m_cnt  [4];
  int         m_ptr;
  logic       last_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_last[i] = '0;
      m_cnt[i]  = 0;
    end
    m_ptr = 0;
  endtask

  task automatic check_state();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lane%0d_valid", i), 32'(out_valid[i]), 32'(m_full[i]));
      chk($sformatf("lane%0d_data", i), 32'(od[i]), 32'(m_last[i]));
      chk($sformatf("lane%0d_cnt", i), 32'(oc[i]), 32'(m_cnt[i]));
    end
  endtask

  task automatic drive(input bit v, input int s, input int dat, input logic [3:0] rdy);
    in_valid  = v;
    in_sel    = 2'(s);
    in_data   = 4'(dat);
    out_ready = rdy;
  endtask

  // One clock: check in_ready, advance the model across the edge, check state.
  task automatic tick();
    int d;
    bit rdy_exp;
    bit acc;
    #1;
`ifdef DEMUX_RR_EN
    d = m_ptr;
`else
    d = int'(in_sel);
`endif
    rdy_exp = !m_full[d] || out_ready[d];
    chk("in_ready", 32'(in_ready), 32'(rdy_exp));
    last_rdy = in_ready;
    acc = in_valid && rdy_exp;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (m_full[i] && out_ready[i]) m_full[i] = 1'b0;
    end
    if (acc) begin
      m_full[d] = 1'b1;
      m_last[d] = in_data;
      m_cnt[d]  = (m_cnt[d] + 1) % 256;
      m_ptr     = (m_ptr + 1) % 4;
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset();
    model_clear();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'($urandom_range(0, 3));
    out_ready = 4'($urandom);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    check_state();
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_in_ready", 32'(in_ready), 32'd1);
    check_state();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check_state();
  endtask

  initial begin
    bit hold;
    #2;
    do_reset();

`ifndef DEMUX_RR_EN
    // Steering to each lane on consecutive cycles.
    drive(1, 2, 4'hA, 4'b1111); tick();
    drive(1, 0, 4'h3, 4'b1111); tick();
    drive(1, 3, 4'hF, 4'b1111); tick();
    drive(1, 1, 4'h5, 4'b1111); tick();
    drive(0, 0, 0, 4'b1111);    tick();
    for (int i = 0; i < 4; i++) chk($sformatf("steer_cnt%0d", i), 32'(oc[i]), 32'd1);

    // Back-pressure on lane 1 while lane 0 stays free.
    drive(1, 1, 4'h7, 4'b1101); tick();
    drive(1, 1, 4'h9, 4'b1101); tick();
    chk("bp_rdy_blocked", 32'(last_rdy), 32'd0);
    chk("bp_hold_data", 32'(out_data1), 32'h7);
    tick();
    chk("bp_rdy_blocked2", 32'(last_rdy), 32'd0);
    drive(1, 1, 4'h9, 4'b1111); tick();
    chk("bp_rdy_release", 32'(last_rdy), 32'd1);
    chk("bp_replace_valid", 32'(out_valid[1]), 32'd1);
    chk("bp_replace_data", 32'(out_data1), 32'h9);
    drive(1, 0, 4'h2, 4'b1111); tick();
    chk("bp_lane0_data", 32'(out_data0), 32'h2);
    drive(0, 0, 0, 4'b1111);    tick();

    // Back-to-back drain and load on lane 2.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1, 2, k, 4'b1111); tick();
      chk("dl_valid2", 32'(out_valid[2]), 32'd1);
      chk("dl_data2", 32'(out_data2), 32'(k));
    end
    drive(0, 0, 0, 4'b1111); tick();
    chk("dl_cnt2", 32'(lane_cnt2), 32'd10);

    // Lane 0 counter wraps after 256 beats.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      drive(1, 0, $urandom, 4'b1111); tick();
    end
    chk("wrap_cnt0", 32'(lane_cnt0), 32'd0);
    chk("wrap_cnt1", 32'(lane_cnt1), 32'd0);
    chk("wrap_cnt3", 32'(lane_cnt3), 32'd0);
`else
    // Round-robin order with lane 2 blocked from beat 3 onwards.
    for (int k = 1; k <= 6; k++) begin
      drive(1, 3, k, (k >= 3) ? 4'b1011 : 4'b1111); tick();
      chk("rr_accept", 32'(last_rdy), 32'd1);
    end
    chk("rr_lane0", 32'(out_data0), 32'h5);
    chk("rr_lane1", 32'(out_data1), 32'h6);
    chk("rr_lane2", 32'(out_data2), 32'h3);
    chk("rr_lane3", 32'(out_data3), 32'h4);
    drive(1, 3, 7, 4'b1011); tick();
    chk("rr_stall", 32'(last_rdy), 32'd0);
    tick();
    chk("rr_stall2", 32'(last_rdy), 32'd0);
    drive(1, 3, 7, 4'b1111); tick();
    chk("rr_resume", 32'(out_data2), 32'h7);
    drive(1, 3, 8, 4'b1111); tick();
    chk("rr_next", 32'(out_data3), 32'h8);
    drive(0, 0, 0, 4'b1111); tick();
`endif

    // Random traffic, producer holds a stalled beat, reset mid-stream.
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        do_reset();
        hold = 1'b0;
      end
      if (!hold) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom, 4'($urandom | $urandom));
      end else begin
        out_ready = 4'($urandom);
      end
      tick();
      hold = in_valid && !last_rdy;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stream_demux4
